iq_upconverter: RTL and testbench
=================================

Name: iq_upconverter

Overview:
- Digital upconverter directly downstream of baseband_dsp, in the dsp_clk domain.
- Consumes the 10-bit signed I/Q pulse-shaped samples and mixes them with an on-chip NCO.
- Produces a single real IF sample stream: IF = I*cos(phi) - Q*sin(phi), for the DAC interface.
- Phase advances once per accepted sample, so the carrier is defined in cycles per sample.

Parameters:
DATA_W, 10, width of signed I/Q input samples
PHASE_W, 24, phase accumulator / frequency word width
LUT_ADDR_W, 8, NCO table address width (phase MSBs used; full-cycle table, 2^LUT_ADDR_W entries)
OUT_W, 12, width of signed IF output

Ports:
dsp_clk  input  1  sole clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  i_in/q_in valid this cycle (no backpressure; every valid sample accepted)
i_in  input  DATA_W  signed I sample (from baseband_dsp I_out)
q_in  input  DATA_W  signed Q sample (from baseband_dsp Q_out)
freq_word  input  PHASE_W  unsigned phase increment per accepted sample
freq_load  input  1  capture freq_word into active increment register
phase_clr  input  1  synchronous clear of phase accumulator
out_valid  output  1  if_out valid
if_out  output  OUT_W  signed IF sample

Behaviour:
- One clock (dsp_clk); reset is synchronous and active-high (rst). rst sampled only on dsp_clk rising edge.
- Reset values: phase_acc=0, freq_active=0, all pipeline valid bits=0, out_valid=0, if_out=0.
- Reset mid-operation flushes the pipeline. Samples in flight are dropped, not emitted.
- NCO table: sin[k]=round(511*sin(2*pi*k/256)), 10-bit signed. cos[k]=sin[(k+64) mod 256]. Address = phase_acc[PHASE_W-1 -: LUT_ADDR_W]. No dither.
- Pipeline, fixed latency 4 cycles from in_valid edge to out_valid. A valid bit travels with the data. Stages advance every cycle. Gaps in in_valid produce identical gaps in out_valid.
- S0 (accept):
  - On in_valid, register i_in, q_in and the current phase_acc address.
  - Then phase_acc <= phase_acc + freq_active, wrapping modulo 2^PHASE_W.
- S1: registered table lookup of cos and sin.
- S2: registered signed products I*cos and Q*sin, 2*DATA_W bits each.
- S3:
  - diff = I*cos - Q*sin, computed at 2*DATA_W+1 bits.
  - Add 256, then arithmetic shift right 9 (round half up).
  - Saturate to [-2048, 2047]; register into if_out.
- if_out holds its last value while out_valid=0.
- freq_load: freq_active <= freq_word at the edge. The increment applied at that same edge uses the pre-load freq_active. The new word affects the phase of the second sample accepted after the load.
- phase_clr: phase_acc <= 0, with priority over the increment. A sample accepted in the same cycle uses the pre-clear phase. The next accepted sample uses phase 0.
- freq_load and phase_clr together: both take effect.
- rst has priority over all.
- Unused phase LSBs below the table address are truncated.

Decomposition:
- Shared package/header upconv_pkg.vh: DATA_W, PHASE_W, LUT_ADDR_W, OUT_W defaults, ROUND_CONST=256, SHIFT=9, OUT_MAX=2047, OUT_MIN=-2048, NCO amplitude 511.
- One sub-module: nco_sin_lut, a synchronous single-read dual-output ROM (sin and cos from one address, cos via +64 offset).
  - Contents come from a generated table include file.
  - Owns stage S1.

Test Plan:
- Reset/hold: assert rst 3 cycles mid-stream with in_valid=1 -> out_valid=0 and if_out=0 from the first edge after rst; no stale sample emerges afterward; first post-reset output appears exactly 4 cycles after first in_valid.
- DC carrier: freq_load with freq_word=0, I=256, Q=100 continuous -> if_out=256 every cycle, out_valid continuous, latency 4.
- Quarter-rate carrier:
  - freq_word=2^22, phase_clr, then I=256, Q=0 -> if_out sequence 256, 0, -255, 0 repeating.
  - Same with I=0, Q=256 -> 0, -255, 0, 256.
- Valid gaps/wrap: freq_word=2^22, in_valid pattern 1,0,0,1,1 -> out_valid same pattern delayed 4. Phase advances only on valid (outputs 256, 0, -255). Run 1000 samples -> phase wraps cleanly, sequence periodic.
- Saturation/extremes: I=-512, Q=511 at phase index 32 (45 degrees, cos=sin=361) -> diff=-369303 -> if_out=-721. Force the table model to amplitude 1023 via the bench's LUT override -> if_out clamps at -2048/2047.
- Control collisions:
  - freq_load (0 -> 2^22) together with in_valid -> that sample and the next use phase 0; increments start after.
  - phase_clr with in_valid -> current sample uses old phase, the next uses phase 0.

Source files
------------

// File: rtl/iq_upconverter_pkg.sv
// Shared constants and NCO table contents for the IQ upconverter.
// The table holds one quarter wave of round(511*sin(2*pi*k/256)), k = 0..64;
// nco_sin() unfolds it to the full 256-entry cycle and rescales it when a
// different peak amplitude is requested.
package iq_upconverter_pkg;

  localparam int DATA_W_DEF     = 10;
  localparam int PHASE_W_DEF    = 24;
  localparam int LUT_ADDR_W_DEF = 8;
  localparam int OUT_W_DEF      = 12;
  localparam int NCO_AMP_DEF    = 511;

  localparam int ROUND_CONST = 256;
  localparam int SHIFT       = 9;
  localparam int OUT_MAX     = 2047;
  localparam int OUT_MIN     = -2048;

  localparam int SIN_Q511 [0:64] = '{
      0,  13,  25,  38,  50,  63,  75,  87, 100, 112, 124, 136, 148, 160, 172, 184,
    196, 207, 218, 230, 241, 252, 263, 273, 284, 294, 304, 314, 324, 334, 343, 352,
    361, 370, 379, 387, 395, 403, 410, 418, 425, 432, 438, 445, 451, 456, 462, 467,
    472, 477, 481, 485, 489, 492, 496, 499, 501, 503, 505, 507, 509, 510, 510, 511,
    511
  };

  // Signed width needed to hold +/-amp.
  function automatic int coef_width(input int amp);
    return $clog2(amp + 1) + 1;
  endfunction

  // Full-cycle sine sample k of 256, peak amplitude amp.
  function automatic int nco_sin(input logic [7:0] k, input int amp);
    logic [6:0] h;
    logic [6:0] idx;
    int         mag;
    h   = k[6:0];
    idx = (h > 7'd64) ? 7'(8'd128 - {1'b0, h}) : h;
    mag = (SIN_Q511[idx] * amp * 2 + NCO_AMP_DEF) / (2 * NCO_AMP_DEF);
    return k[7] ? -mag : mag;
  endfunction

endpackage

// File: rtl/iq_upconverter_nco_sin_lut.sv
// nco_sin_lut: synchronous single-read ROM returning sin and cos of one
// phase address (cos read a quarter cycle ahead). Owns pipeline stage S1.
//   clk      : rising-edge clock
//   addr     : phase table address (top bits of the phase accumulator)
//   sin_p1   : registered sine coefficient
//   cos_p1   : registered cosine coefficient
module nco_sin_lut
  import iq_upconverter_pkg::*;
#(
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int NCO_AMP    = NCO_AMP_DEF,
  parameter int COEF_W     = coef_width(NCO_AMP_DEF)
) (
  input  logic                     clk,
  input  logic [LUT_ADDR_W-1:0]    addr,
  output logic signed [COEF_W-1:0] sin_p1,
  output logic signed [COEF_W-1:0] cos_p1
);

  logic [7:0] k;
  assign k = 8'(addr);

  // ---- S1: table read ----
  always_ff @(posedge clk) begin
    sin_p1 <= COEF_W'(nco_sin(k, NCO_AMP));
    cos_p1 <= COEF_W'(nco_sin(k + 8'd64, NCO_AMP));
  end

endmodule

// File: rtl/iq_upconverter.sv
// iq_upconverter: mixes baseband I/Q with an on-chip NCO into one real IF
// stream, IF = I*cos(phi) - Q*sin(phi). Fixed 4-cycle latency; the phase
// advances once per accepted sample.
//   dsp_clk, rst        : clock, synchronous active-high reset
//   in_valid, i_in, q_in: input samples (always accepted)
//   freq_word, freq_load: phase increment and its load strobe
//   phase_clr           : clear phase accumulator
//   out_valid, if_out   : IF output (if_out holds while out_valid is low)
module iq_upconverter
  import iq_upconverter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int NCO_AMP    = NCO_AMP_DEF
) (
  input  logic                     dsp_clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  input  logic [PHASE_W-1:0]       freq_word,
  input  logic                     freq_load,
  input  logic                     phase_clr,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  if_out
);

  localparam int COEF_W = coef_width(NCO_AMP);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int DIFF_W = PROD_W + 1;
  localparam int RND_W  = DIFF_W + 1;
  localparam int SHR_W  = RND_W - SHIFT;

  logic [PHASE_W-1:0]        phase_acc;
  logic [PHASE_W-1:0]        freq_active;
  logic                      vld_p0, vld_p1, vld_p2;
  logic signed [DATA_W-1:0]  i_p0, q_p0, i_p1, q_p1;
  logic [LUT_ADDR_W-1:0]     addr_p0;
  logic signed [COEF_W-1:0]  sin_p1, cos_p1;
  logic signed [PROD_W-1:0]  prod_i_p2, prod_q_p2;
  logic signed [DIFF_W-1:0]  diff_p2;

  // Add half an LSB of the output scale, then drop SHIFT bits (round half up).
  function automatic logic signed [SHR_W-1:0] round_shift(input logic signed [DIFF_W-1:0] d);
    logic signed [RND_W-1:0] t;
    t = RND_W'(d) + RND_W'(ROUND_CONST);
    return t[RND_W-1:SHIFT];
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [SHR_W-1:0] v);
    if (v > SHR_W'(OUT_MAX))
      return OUT_W'(OUT_MAX);
    else if (v < SHR_W'(OUT_MIN))
      return OUT_W'(OUT_MIN);
    else
      return OUT_W'(v);
  endfunction

  // Control path: phase/frequency state, valid chain and output register.
  // The sample accepted in a clear/load cycle still sees the old phase and
  // increment, so the clear wins over the increment only for later samples.
  always_ff @(posedge dsp_clk) begin
    if (rst) begin
      phase_acc   <= '0;
      freq_active <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_valid   <= 1'b0;
      if_out      <= '0;
    end else begin
      if (freq_load)
        freq_active <= freq_word;
      if (phase_clr)
        phase_acc <= '0;
      else if (in_valid)
        phase_acc <= phase_acc + freq_active;
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      // ---- S3: round, saturate, output ----
      if (vld_p2)
        if_out <= saturate(round_shift(diff_p2));
    end
  end

  // ---- S0: accept sample and phase address ----
  always_ff @(posedge dsp_clk) begin
    if (in_valid) begin
      i_p0    <= i_in;
      q_p0    <= q_in;
      addr_p0 <= phase_acc[PHASE_W-1 -: LUT_ADDR_W];
    end
  end

  // ---- S1: table lookup ----
  nco_sin_lut #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .NCO_AMP    (NCO_AMP),
    .COEF_W     (COEF_W)
  ) u_lut (
    .clk    (dsp_clk),
    .addr   (addr_p0),
    .sin_p1 (sin_p1),
    .cos_p1 (cos_p1)
  );

  always_ff @(posedge dsp_clk) begin
    i_p1 <= i_p0;
    q_p1 <= q_p0;
  end

  // ---- S2: products ----
  always_ff @(posedge dsp_clk) begin
    prod_i_p2 <= PROD_W'(i_p1) * PROD_W'(cos_p1);
    prod_q_p2 <= PROD_W'(q_p1) * PROD_W'(sin_p1);
  end

  assign diff_p2 = DIFF_W'(prod_i_p2) - DIFF_W'(prod_q_p2);

endmodule

// File: tb/tb_iq_upconverter.sv
// Directed bench for iq_upconverter. Outputs are logged every cycle on the
// falling edge; a sample driven while the cycle counter reads t is expected
// in the log at t+4.
module tb_iq_upconverter;
  import iq_upconverter_pkg::*;

  localparam int LOG_N = 4096;

  logic                          dsp_clk = 1'b0;
  logic                          rst;
  logic                          in_valid;
  logic signed [DATA_W_DEF-1:0]  i_in, q_in;
  logic [PHASE_W_DEF-1:0]        freq_word;
  logic                          freq_load, phase_clr;
  logic                          out_valid, out_valid_s;
  logic signed [OUT_W_DEF-1:0]   if_out, if_out_s;

  always #5 dsp_clk = ~dsp_clk;

  iq_upconverter dut (
    .dsp_clk (dsp_clk), .rst (rst), .in_valid (in_valid),
    .i_in (i_in), .q_in (q_in), .freq_word (freq_word),
    .freq_load (freq_load), .phase_clr (phase_clr),
    .out_valid (out_valid), .if_out (if_out)
  );

  // Table amplitude raised so full-scale inputs reach the output rails; with
  // 10-bit inputs even a 1023 peak tops out near +/-1447.
  iq_upconverter #(.NCO_AMP(4095)) dut_sat (
    .dsp_clk (dsp_clk), .rst (rst), .in_valid (in_valid),
    .i_in (i_in), .q_in (q_in), .freq_word (freq_word),
    .freq_load (freq_load), .phase_clr (phase_clr),
    .out_valid (out_valid_s), .if_out (if_out_s)
  );

  int   cyc = 0;
  logic ov_log  [LOG_N];
  int   if_log  [LOG_N];
  logic ovs_log [LOG_N];
  int   ifs_log [LOG_N];

  always @(posedge dsp_clk) cyc <= cyc + 1;

  always @(negedge dsp_clk) begin
    if (cyc < LOG_N) begin
      ov_log[cyc]  = out_valid;
      if_log[cyc]  = int'(if_out);
      ovs_log[cyc] = out_valid_s;
      ifs_log[cyc] = int'(if_out_s);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic put(input logic v, input int i, input int q, output int t);
    in_valid = v;
    i_in     = DATA_W_DEF'(i);
    q_in     = DATA_W_DEF'(q);
    t        = cyc;
    step();
    in_valid  = 1'b0;
    freq_load = 1'b0;
    phase_clr = 1'b0;
  endtask

  task automatic ctl(input int fw, input logic ld, input logic clr);
    int t;
    freq_word = PHASE_W_DEF'(fw);
    freq_load = ld;
    phase_clr = clr;
    put(1'b0, 0, 0, t);
  endtask

  task automatic flush();
    repeat (6) step();
  endtask

  task automatic expect_out(input string tag, input int t, input int v);
    check_eq($sformatf("%s_vld@%0d", tag, t), int'(ov_log[t + 4]), 1);
    check_eq($sformatf("%s_if@%0d", tag, t), if_log[t + 4], v);
  endtask

  int t, t0;
  int ts [8];
  int tr [3];
  int tp [4];
  int quad_i [4] = '{256, 0, -255, 0};
  int quad_q [4] = '{0, -255, 0, 256};
  logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int gap_exp [3] = '{256, 0, -255};
  int ext_i [3] = '{-512, -512, 511};
  int ext_q [3] = '{511, 511, -512};
  int ext_main [3] = '{-511, -721, 511};
  int ext_sat [3] = '{-2048, -2048, 2047};
  int col_exp [7] = '{256, 256, 0, -255, 0, 256, 0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; i_in = '0; q_in = '0;
    freq_word = '0; freq_load = 1'b0; phase_clr = 1'b0;
    repeat (3) step();
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_if_out", int'(if_out), 0);
    check_eq("rst_sat_if_out", int'(if_out_s), 0);
    rst = 1'b0;

    // DC carrier: zero increment, phase 0 -> I passes straight through.
    ctl(0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) put(1'b1, 256, 100, ts[k]);
    flush();
    check_eq("dc_latency_gap", int'(ov_log[ts[0] + 3]), 0);
    for (int k = 0; k < 8; k++) expect_out("dc", ts[k], 256);

    // Reset mid-stream with in_valid held high.
    for (int k = 0; k < 6; k++) put(1'b1, 256, 100, t);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) put(1'b1, 256, 100, tr[k]);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) put(1'b1, 256, 100, tp[k]);
    flush();
    for (int c = tr[0] + 1; c <= tp[0] + 3; c++) begin
      check_eq($sformatf("rst_flush_vld@%0d", c), int'(ov_log[c]), 0);
      check_eq($sformatf("rst_flush_if@%0d", c), if_log[c], 0);
    end
    for (int k = 0; k < 4; k++) expect_out("post_rst", tp[k], 256);

    // Quarter-rate carrier, I only then Q only.
    ctl(1 << 22, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) put(1'b1, 256, 0, ts[k]);
    flush();
    for (int k = 0; k < 8; k++) expect_out("quad_i", ts[k], quad_i[k % 4]);
    ctl(1 << 22, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) put(1'b1, 0, 256, ts[k]);
    flush();
    for (int k = 0; k < 4; k++) expect_out("quad_q", ts[k], quad_q[k]);

    // Valid gaps: phase only moves on accepted samples, if_out holds in gaps.
    ctl(1 << 22, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) put(pat[k], 256, 0, ts[k]);
    flush();
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("gap_vld[%0d]", k), int'(ov_log[ts[k] + 4]), int'(pat[k]));
    check_eq("gap_if[0]", if_log[ts[0] + 4], gap_exp[0]);
    check_eq("gap_hold", if_log[ts[2] + 4], gap_exp[0]);
    check_eq("gap_if[3]", if_log[ts[3] + 4], gap_exp[1]);
    check_eq("gap_if[4]", if_log[ts[4] + 4], gap_exp[2]);

    // Long run across many accumulator wraps.
    ctl(1 << 22, 1'b0, 1'b1);
    put(1'b1, 256, 0, t0);
    for (int k = 1; k < 1000; k++) put(1'b1, 256, 0, t);
    flush();
    for (int k = 0; k < 1000; k++) expect_out("wrap", t0 + k, quad_i[k % 4]);

    // Extremes at phase index 0, 32 and 64 (step of 32 entries).
    ctl(1 << 21, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) put(1'b1, ext_i[k], ext_q[k], ts[k]);
    flush();
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("ext%0d", k), ts[k], ext_main[k]);
      check_eq($sformatf("sat_vld[%0d]", k), int'(ovs_log[ts[k] + 4]), 1);
      check_eq($sformatf("sat_if[%0d]", k), ifs_log[ts[k] + 4], ext_sat[k]);
    end

    // Load together with a sample, then clear together with a sample.
    ctl(0, 1'b1, 1'b1);
    freq_word = PHASE_W_DEF'(1 << 22);
    freq_load = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) phase_clr = 1'b1;
      put(1'b1, 256, 0, ts[k]);
    end
    flush();
    for (int k = 0; k < 7; k++) expect_out($sformatf("coll%0d", k), ts[k], col_exp[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
